prim_clock_gate_ctrl: RTL and testbench

PRIM_CLOCK_GATE_CTRL -- requirements
Module: prim_clock_gate_ctrl

---
 rtl/prim_clock_gate_ctrl.sv | 121 ++++++++++++
 tb/tb_prim_clock_gate_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prim_clock_gate_ctrl.sv
// Per-channel clock gating with demand/hold FSM and glitch-free latch-based gates.
// Optional per-channel gated-cycle statistics are built when PRIM_CLKGATE_STATS_EN is defined.
module prim_clock_gate_ctrl #(
  parameter int NumCh      = 4,
  parameter int HoldCycles = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  test_en_i,
  input  logic                  force_on_i,
  input  logic [NumCh-1:0]      en_i,
  output logic [NumCh-1:0]      ack_o,
  output logic [NumCh-1:0]      clk_o,
  output logic [NumCh*16-1:0]   gated_cnt_o
);

  // state   | meaning
  // StOff   | clock gated, waiting for demand
  // StOn    | clock running on demand or force
  // StHold  | demand gone, clock kept running until hold counter expires
  typedef enum logic [1:0] {
    StOff  = 2'd0,
    StOn   = 2'd1,
    StHold = 2'd2
  } state_e;

  localparam int CntW = (HoldCycles > 0) ? $clog2(HoldCycles + 1) : 1;
  localparam logic [CntW-1:0] HoldLoad = (HoldCycles > 0) ? CntW'(HoldCycles - 1) : '0;

  state_e            state_q [NumCh];
  state_e            state_d [NumCh];
  logic [CntW-1:0]   cnt_q   [NumCh];
  logic [CntW-1:0]   cnt_d   [NumCh];
  logic [NumCh-1:0]  gate_en_q;
  logic [NumCh-1:0]  gate_en_d;
  logic [NumCh-1:0]  en_latch;

  always_comb begin
    for (int i = 0; i < NumCh; i++) begin
      state_d[i]   = state_q[i];
      cnt_d[i]     = cnt_q[i];
      case (state_q[i])
        StOn: begin
          if (!(en_i[i] || force_on_i)) begin
            if (HoldCycles == 0) begin
              state_d[i] = StOff;
            end else begin
              state_d[i] = StHold;
              cnt_d[i]   = HoldLoad;
            end
          end
        end
        StHold: begin
          if (en_i[i] || force_on_i) begin
            state_d[i] = StOn;
          end else if (cnt_q[i] == '0) begin
            state_d[i] = StOff;
          end else begin
            cnt_d[i] = cnt_q[i] - CntW'(1);
          end
        end
        default: begin
          if (en_i[i] || force_on_i) state_d[i] = StOn;
        end
      endcase
      gate_en_d[i] = (state_d[i] != StOff);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumCh; i++) begin
        state_q[i] <= StOff;
        cnt_q[i]   <= '0;
      end
      gate_en_q <= '0;
    end else begin
      for (int i = 0; i < NumCh; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      gate_en_q <= gate_en_d;
    end
  end

  assign ack_o = gate_en_q;

  // Latch is transparent only while clk_i is low, so the AND never sees an enable change in the high phase.
  always_latch begin
    if (!clk_i) en_latch = gate_en_q | {NumCh{test_en_i}};
  end

  assign clk_o = {NumCh{clk_i}} & en_latch;

`ifdef PRIM_CLKGATE_STATS_EN
  logic [15:0] stat_q [NumCh];
  logic [15:0] stat_d [NumCh];

  always_comb begin
    for (int i = 0; i < NumCh; i++) begin
      stat_d[i] = stat_q[i];
      if (!gate_en_q[i] && (stat_q[i] != 16'hFFFF)) stat_d[i] = stat_q[i] + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumCh; i++) stat_q[i] <= '0;
    end else begin
      for (int i = 0; i < NumCh; i++) stat_q[i] <= stat_d[i];
    end
  end

  for (genvar g = 0; g < NumCh; g++) begin : g_stat_out
    assign gated_cnt_o[16*g +: 16] = stat_q[g];
  end
`else
  assign gated_cnt_o = '0;
`endif

endmodule

// File: tb/tb_prim_clock_gate_ctrl.sv
// Self-checking bench for prim_clock_gate_ctrl (NumCh=4, HoldCycles=8), scoreboard of expected ack_o.
module tb_prim_clock_gate_ctrl;
  localparam int NumCh = 4;
  localparam int Hold  = 8;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              test_en_i;
  logic              force_on_i;
  logic [NumCh-1:0]  en_i;
  logic [NumCh-1:0]  ack_o;
  logic [NumCh-1:0]  clk_o;
  logic [NumCh*16-1:0] gated_cnt_o;

  int n_cmp = 0;
  int n_mis = 0;
  logic [NumCh-1:0] sb [$];
  logic [NumCh-1:0] exp_v;
  int pulses0 = 0, pulses1 = 0, pulses2 = 0, pulses3 = 0;

  prim_clock_gate_ctrl #(.NumCh(NumCh), .HoldCycles(Hold)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .test_en_i   (test_en_i),
    .force_on_i  (force_on_i),
    .en_i        (en_i),
    .ack_o       (ack_o),
    .clk_o       (clk_o),
    .gated_cnt_o (gated_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_o[0]) pulses0++;
  always @(posedge clk_o[1]) pulses1++;
  always @(posedge clk_o[2]) pulses2++;
  always @(posedge clk_o[3]) pulses3++;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; test_en_i = 1'b0; force_on_i = 1'b0; en_i = '0;
    repeat (3) step();
    #2;
    n_cmp++;
    if (ack_o !== 4'b0000) begin
      n_mis++; $display("FAIL reset_ack: got %b want %b", ack_o, 4'b0000);
    end
    n_cmp++;
    if (clk_o !== 4'b0000) begin
      n_mis++; $display("FAIL reset_clk: got %b want %b", clk_o, 4'b0000);
    end
    n_cmp++;
    if (gated_cnt_o !== '0) begin
      n_mis++; $display("FAIL reset_stats: got %h want 0", gated_cnt_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    step();
    sb.push_back(4'b0000);
    exp_v = sb.pop_front();
    n_cmp++;
    if (ack_o !== exp_v) begin
      n_mis++; $display("FAIL post_reset_ack: got %b want %b", ack_o, exp_v);
    end
  endtask

  task automatic test_wake();
    int p0, p1, p2, p3;
    @(negedge clk_i);
    en_i = 4'b0001;
    sb.push_back(4'b0001);
    p0 = pulses0; p1 = pulses1; p2 = pulses2; p3 = pulses3;
    step();
    exp_v = sb.pop_front();
    n_cmp++;
    if (ack_o !== exp_v) begin
      n_mis++; $display("FAIL wake_ack: got %b want %b", ack_o, exp_v);
    end
    n_cmp++;
    if (pulses0 - p0 != 0) begin
      n_mis++; $display("FAIL wake_early_pulse: got %0d want 0", pulses0 - p0);
    end
    step();
    n_cmp++;
    if (clk_o !== 4'b0001) begin
      n_mis++; $display("FAIL wake_first_pulse: got %b want %b", clk_o, 4'b0001);
    end
    n_cmp++;
    if ((pulses0 - p0 != 1) || (pulses1 != p1) || (pulses2 != p2) || (pulses3 != p3)) begin
      n_mis++;
      $display("FAIL wake_pulse_count: got %0d/%0d/%0d/%0d want 1/0/0/0",
               pulses0 - p0, pulses1 - p1, pulses2 - p2, pulses3 - p3);
    end
    @(negedge clk_i);
    en_i = '0;
    repeat (12) step();
  endtask

  task automatic test_hold_expiry();
    int p0;
    @(negedge clk_i);
    en_i = 4'b0001;
    step(); step();
    @(negedge clk_i);
    en_i = 4'b0000;
    for (int j = 0; j <= 10; j++) sb.push_back((j < Hold) ? 4'b0001 : 4'b0000);
    step();
    p0 = pulses0;
    for (int j = 0; j <= 10; j++) begin
      if (j > 0) step();
      exp_v = sb.pop_front();
      n_cmp++;
      if (ack_o !== exp_v) begin
        n_mis++; $display("FAIL hold_ack[%0d]: got %b want %b", j, ack_o, exp_v);
      end
    end
    n_cmp++;
    if (pulses0 - p0 != Hold) begin
      n_mis++; $display("FAIL hold_pulses: got %0d want %0d", pulses0 - p0, Hold);
    end
  endtask

  task automatic test_rerequest();
    int p0;
    @(negedge clk_i);
    en_i = 4'b0001;
    step(); step();
    p0 = pulses0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk_i);
      en_i = (j >= 4) ? 4'b0001 : 4'b0000;
      sb.push_back(4'b0001);
      step();
      exp_v = sb.pop_front();
      n_cmp++;
      if (ack_o !== exp_v) begin
        n_mis++; $display("FAIL rereq_ack[%0d]: got %b want %b", j, ack_o, exp_v);
      end
    end
    n_cmp++;
    if (pulses0 - p0 != 10) begin
      n_mis++; $display("FAIL rereq_pulses: got %0d want 10", pulses0 - p0);
    end
    @(negedge clk_i);
    en_i = '0;
    repeat (12) step();
  endtask

  task automatic test_force();
    @(negedge clk_i);
    en_i = '0; force_on_i = 1'b1;
    sb.push_back(4'b1111);
    step();
    exp_v = sb.pop_front();
    n_cmp++;
    if (ack_o !== exp_v) begin
      n_mis++; $display("FAIL force_ack: got %b want %b", ack_o, exp_v);
    end
    @(negedge clk_i);
    force_on_i = 1'b0;
    for (int j = 0; j <= 8; j++) sb.push_back((j < Hold) ? 4'b1111 : 4'b0000);
    for (int j = 0; j <= 8; j++) begin
      step();
      exp_v = sb.pop_front();
      n_cmp++;
      if (ack_o !== exp_v) begin
        n_mis++; $display("FAIL force_release_ack[%0d]: got %b want %b", j, ack_o, exp_v);
      end
    end
  endtask

  task automatic test_test_en_reset();
    @(negedge clk_i);
    rst_ni = 1'b0; test_en_i = 1'b1;
    @(posedge clk_i); #2;
    n_cmp++;
    if (clk_o !== 4'b1111) begin
      n_mis++; $display("FAIL testen_clk_high: got %b want %b", clk_o, 4'b1111);
    end
    n_cmp++;
    if (ack_o !== 4'b0000) begin
      n_mis++; $display("FAIL testen_ack: got %b want %b", ack_o, 4'b0000);
    end
    @(negedge clk_i); #2;
    n_cmp++;
    if (clk_o !== 4'b0000) begin
      n_mis++; $display("FAIL testen_clk_low: got %b want %b", clk_o, 4'b0000);
    end
    test_en_i = 1'b0;
    @(posedge clk_i); #2;
    n_cmp++;
    if (clk_o !== 4'b0000) begin
      n_mis++; $display("FAIL reset_gated_clk: got %b want %b", clk_o, 4'b0000);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_reset_mid_hold();
    @(negedge clk_i);
    en_i = 4'b0001;
    step(); step();
    @(negedge clk_i);
    en_i = 4'b0000;
    step();
    repeat (4) step();
    #1;
    rst_ni = 1'b0;
    #1;
    n_cmp++;
    if (ack_o !== 4'b0000) begin
      n_mis++; $display("FAIL midhold_ack_async: got %b want %b", ack_o, 4'b0000);
    end
    @(posedge clk_i); #1;
    n_cmp++;
    if (clk_o !== 4'b0000) begin
      n_mis++; $display("FAIL midhold_clk: got %b want %b", clk_o, 4'b0000);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    sb.push_back(4'b0000);
    sb.push_back(4'b0000);
    for (int j = 0; j < 2; j++) begin
      step();
      exp_v = sb.pop_front();
      n_cmp++;
      if (ack_o !== exp_v) begin
        n_mis++; $display("FAIL midhold_off[%0d]: got %b want %b", j, ack_o, exp_v);
      end
    end
  endtask

  // Expected ack: channel high if demand was sampled within the last Hold+1 edges.
  task automatic test_random();
    int since [NumCh];
    logic [NumCh-1:0] v;
    logic [NumCh-1:0] e;
    for (int c = 0; c < NumCh; c++) since[c] = 100;
    for (int j = 0; j < 80; j++) begin
      @(negedge clk_i);
      v = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      en_i = v;
      for (int c = 0; c < NumCh; c++) begin
        since[c] = v[c] ? 0 : since[c] + 1;
        e[c] = (since[c] <= Hold);
      end
      sb.push_back(e);
      step();
      exp_v = sb.pop_front();
      n_cmp++;
      if (ack_o !== exp_v) begin
        n_mis++; $display("FAIL random_ack[%0d]: got %b want %b en %b", j, ack_o, exp_v, v);
      end
    end
    @(negedge clk_i);
    en_i = '0;
    repeat (12) step();
  endtask

  task automatic test_stats();
`ifdef PRIM_CLKGATE_STATS_EN
    logic [15:0] c0;
    @(negedge clk_i);
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    en_i = 4'b0001;
    repeat (3) step();
    c0 = gated_cnt_o[15:0];
    repeat (70000) @(posedge clk_i);
    #1;
    n_cmp++;
    if (gated_cnt_o[31:16] !== 16'hFFFF) begin
      n_mis++; $display("FAIL stats_sat: got %h want ffff", gated_cnt_o[31:16]);
    end
    n_cmp++;
    if (gated_cnt_o[15:0] !== c0) begin
      n_mis++; $display("FAIL stats_active: got %h want %h", gated_cnt_o[15:0], c0);
    end
    en_i = '0;
`else
    repeat (20) step();
    n_cmp++;
    if (gated_cnt_o !== '0) begin
      n_mis++; $display("FAIL stats_tied: got %h want 0", gated_cnt_o);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_wake();
    test_hold_expiry();
    test_rerequest();
    test_force();
    test_test_en_reset();
    test_reset_mid_hold();
    test_random();
    test_stats();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
